// File: rtl/xadc_wiz_pkg.sv
// Shared definitions for the XADC wizard model: DRP address map, channel
// codes, data typedef, sequencer state encoding and code-saturation helper.
package xadc_wiz_pkg;

    // DRP address map
    localparam logic [6:0] ADDR_AUX0 = 7'h10;
    localparam logic [6:0] ADDR_AUX1 = 7'h11;
    localparam logic [6:0] CFG_BASE  = 7'h40;

    // Channel codes reported on channel_out
    localparam logic [4:0] CH_AUX0 = 5'h10;
    localparam logic [4:0] CH_AUX1 = 5'h11;

    // Width of a conversion result
    localparam int CODE_W = 12;

    typedef logic [15:0] drp_data_t;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_ACQ    = 2'd1,
        SEQ_RESULT = 2'd2
    } seq_state_t;

    // True for the sixteen config registers 0x40..0x4F
    function automatic logic is_cfg_addr(input logic [6:0] addr);
        return (addr[6:4] == CFG_BASE[6:4]);
    endfunction

    // Clamp a 13-bit scaled duty count to the 12-bit full-scale code
    function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W:0] scaled);
        logic [CODE_W-1:0] code;
        if (scaled[CODE_W]) begin
            code = 12'hFFF;
        end else begin
            code = scaled[CODE_W-1:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/xadc_wiz_drp_port.sv
// DRP slave: accepts one transaction at a time, captures read data in the
// enable cycle, answers DRP_LATENCY clocks later and owns the config registers.
module xadc_drp_port
    import xadc_wiz_pkg::*;
#(
    parameter int DRP_LATENCY = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_daddr,
    input  logic       i_den,
    input  logic       i_dwe,
    input  drp_data_t  i_di,
    input  drp_data_t  i_stat0,
    input  drp_data_t  i_stat1,
    output drp_data_t  o_do,
    output logic       o_drdy
);

    localparam int LAT_W = (DRP_LATENCY > 1) ? $clog2(DRP_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_M1  = LAT_W'(DRP_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1'b1);

    logic             r_pending;
    logic [LAT_W-1:0] r_lat;
    logic             r_is_wr;
    drp_data_t        r_rdata;
    drp_data_t        r_do;
    logic             r_drdy;
    drp_data_t        r_cfg [16];

    logic      w_accept;
    drp_data_t w_rd_mux;

    // An enable is taken only when no transaction is in flight
    always_comb begin
        w_accept = i_den & ~r_pending;
    end

    // Read mux over status and config registers, sampled in the enable cycle
    always_comb begin
        w_rd_mux = 16'h0000;
        if (i_daddr == ADDR_AUX0) begin
            w_rd_mux = i_stat0;
        end else if (i_daddr == ADDR_AUX1) begin
            w_rd_mux = i_stat1;
        end else if (is_cfg_addr(i_daddr)) begin
            w_rd_mux = r_cfg[i_daddr[3:0]];
        end else begin
            w_rd_mux = 16'h0000;
        end
    end

    // Transaction pipeline: pending flag, latency countdown, ready pulse and read data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_lat     <= '0;
            r_is_wr   <= 1'b0;
            r_rdata   <= 16'h0000;
            r_do      <= 16'h0000;
            r_drdy    <= 1'b0;
        end else begin
            r_drdy <= 1'b0;
            if (w_accept) begin
                r_rdata <= w_rd_mux;
                r_is_wr <= i_dwe;
                if (LAT_M1 == '0) begin
                    // Single-cycle latency answers straight away
                    r_drdy    <= 1'b1;
                    r_pending <= 1'b0;
                    if (!i_dwe) begin
                        r_do <= w_rd_mux;
                    end
                end else begin
                    r_pending <= 1'b1;
                    r_lat     <= LAT_M1;
                end
            end else if (r_pending) begin
                if (r_lat == LAT_ONE) begin
                    r_pending <= 1'b0;
                    r_drdy    <= 1'b1;
                    if (!r_is_wr) begin
                        r_do <= r_rdata;
                    end
                end else begin
                    r_lat <= r_lat - LAT_ONE;
                end
            end
        end
    end

    // Config register file, written by accepted writes in 0x40..0x4F only
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_cfg[i] <= 16'h0000;
            end
        end else begin
            if (w_accept && i_dwe && is_cfg_addr(i_daddr)) begin
                r_cfg[i_daddr[3:0]] <= i_di;
            end
        end
    end

    assign o_do   = r_do;
    assign o_drdy = r_drdy;

endmodule

// File: rtl/xadc_wiz.sv
// XADC wizard behavioural model: free-running two-channel sequencer that
// converts PWM-style aux inputs to 12-bit codes by duty counting, with a DRP
// port for reading results and accessing config registers.
module xadc_wiz
    import xadc_wiz_pkg::*;
#(
    parameter int ACQ_LOG2    = 6,
    parameter int DRP_LATENCY = 4
) (
    input  logic       dclk_in,
    input  logic       reset_in,
    input  logic [6:0] daddr_in,
    input  logic       den_in,
    input  drp_data_t  di_in,
    input  logic       dwe_in,
    output drp_data_t  do_out,
    output logic       drdy_out,
    output logic       busy_out,
    output logic [4:0] channel_out,
    output logic       eoc_out,
    output logic       eos_out,
    output logic       alarm_out,
    input  logic       vp_in,
    input  logic       vn_in,
    input  logic       vauxp0,
    input  logic       vauxn0,
    input  logic       vauxp1,
    input  logic       vauxn1
);

    localparam int CNT_W      = ACQ_LOG2 + 1;
    localparam int CODE_SHIFT = CODE_W - ACQ_LOG2;
    localparam logic [ACQ_LOG2-1:0] WIN_LAST = {ACQ_LOG2{1'b1}};
    localparam logic [ACQ_LOG2-1:0] WIN_ONE  = ACQ_LOG2'(1'b1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [ACQ_LOG2-1:0] r_win_cnt;
    logic [CNT_W-1:0]    r_duty_cnt;
    logic                r_busy;
    logic                r_eoc;
    logic                r_eos;
    logic [4:0]          r_channel;
    drp_data_t           r_stat0;
    drp_data_t           r_stat1;

    logic                w_busy_nxt;
    logic                w_eoc_nxt;
    logic                w_eos_nxt;
    logic [4:0]          w_channel_nxt;
    logic                w_sample;
    logic [CODE_W:0]     w_scaled;
    logic [CODE_W-1:0]   w_code;
    logic                w_unused_pins;

    // The dedicated pair is present on the pinout but never converted
    assign w_unused_pins = vp_in ^ vn_in;

    // Comparator view of the channel being acquired
    always_comb begin
        if (r_channel == CH_AUX1) begin
            w_sample = vauxp1 & ~vauxn1;
        end else begin
            w_sample = vauxp0 & ~vauxn0;
        end
    end

    // Scale the window count to 12 bits; a full window overflows and clamps
    always_comb begin
        w_scaled = (CODE_W + 1)'(r_duty_cnt) << CODE_SHIFT;
        w_code   = sat_code(w_scaled);
    end

    // Sequencer next state and next registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = 1'b0;
        w_eoc_nxt     = 1'b0;
        w_eos_nxt     = 1'b0;
        w_channel_nxt = r_channel;
        case (r_state)
            SEQ_IDLE: begin
                w_state_nxt   = SEQ_ACQ;
                w_busy_nxt    = 1'b1;
                w_channel_nxt = CH_AUX0;
            end
            SEQ_ACQ: begin
                if (r_win_cnt == WIN_LAST) begin
                    w_state_nxt = SEQ_RESULT;
                    w_eoc_nxt   = 1'b1;
                    w_eos_nxt   = (r_channel == CH_AUX1);
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            SEQ_RESULT: begin
                w_state_nxt = SEQ_ACQ;
                w_busy_nxt  = 1'b1;
                if (r_channel == CH_AUX1) begin
                    w_channel_nxt = CH_AUX0;
                end else begin
                    w_channel_nxt = CH_AUX1;
                end
            end
            default: begin
                w_state_nxt   = SEQ_IDLE;
                w_channel_nxt = CH_AUX0;
            end
        endcase
    end

    // Sequencer state and registered status outputs
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= SEQ_IDLE;
            r_busy    <= 1'b0;
            r_eoc     <= 1'b0;
            r_eos     <= 1'b0;
            r_channel <= CH_AUX0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_eoc     <= w_eoc_nxt;
            r_eos     <= w_eos_nxt;
            r_channel <= w_channel_nxt;
        end
    end

    // Window position and duty counter; the count is held through the result cycle
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            r_win_cnt  <= '0;
            r_duty_cnt <= '0;
        end else begin
            case (r_state)
                SEQ_ACQ: begin
                    r_win_cnt  <= r_win_cnt + WIN_ONE;
                    r_duty_cnt <= r_duty_cnt + CNT_W'(w_sample);
                end
                SEQ_RESULT: begin
                    r_win_cnt  <= '0;
                    r_duty_cnt <= '0;
                end
                default: begin
                    r_win_cnt  <= '0;
                    r_duty_cnt <= '0;
                end
            endcase
        end
    end

    // Left-justified result written at the end of the result cycle
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            r_stat0 <= 16'h0000;
            r_stat1 <= 16'h0000;
        end else begin
            if (r_state == SEQ_RESULT) begin
                if (r_channel == CH_AUX1) begin
                    r_stat1 <= {w_code, 4'h0};
                end else begin
                    r_stat0 <= {w_code, 4'h0};
                end
            end
        end
    end

    xadc_drp_port #(
        .DRP_LATENCY (DRP_LATENCY)
    ) u_drp (
        .i_clk   (dclk_in),
        .i_rst   (reset_in),
        .i_daddr (daddr_in),
        .i_den   (den_in),
        .i_dwe   (dwe_in),
        .i_di    (di_in),
        .i_stat0 (r_stat0),
        .i_stat1 (r_stat1),
        .o_do    (do_out),
        .o_drdy  (drdy_out)
    );

    assign busy_out    = r_busy;
    assign channel_out = r_channel;
    assign eoc_out     = r_eoc;
    assign eos_out     = r_eos;
    assign alarm_out   = 1'b0;

endmodule

// File: tb/tb_xadc_wiz.sv
// Bench for xadc_wiz: a cycle-schedule reference model predicts sequencer
// outputs and DRP responses; a negedge monitor checks them via a scoreboard.
`timescale 1ns/1ps
module tb_xadc_wiz;

    localparam int ACQ = 6;
    localparam int LAT = 4;
    localparam int PER = (1 << ACQ) + 1;

    logic        dclk_in  = 1'b0;
    logic        reset_in = 1'b1;
    logic [6:0]  daddr_drv = 7'h00;
    logic        den_drv  = 1'b0;
    logic        dwe_in   = 1'b0;
    logic [15:0] di_in    = 16'h0000;
    logic        chain    = 1'b0;
    logic        vauxp0 = 1'b0, vauxn0 = 1'b0, vauxp1 = 1'b0, vauxn1 = 1'b0;
    int          amode = 0;

    logic        den_w;
    logic [6:0]  daddr_w;
    logic [15:0] do_out;
    logic        drdy_out, busy_out, eoc_out, eos_out, alarm_out;
    logic [4:0]  channel_out;

    assign den_w   = chain ? eoc_out : den_drv;
    assign daddr_w = chain ? {2'b00, channel_out} : daddr_drv;

    xadc_wiz #(.ACQ_LOG2(ACQ), .DRP_LATENCY(LAT)) dut (
        .dclk_in(dclk_in), .reset_in(reset_in), .daddr_in(daddr_w), .den_in(den_w),
        .di_in(di_in), .dwe_in(dwe_in), .do_out(do_out), .drdy_out(drdy_out),
        .busy_out(busy_out), .channel_out(channel_out), .eoc_out(eoc_out),
        .eos_out(eos_out), .alarm_out(alarm_out), .vp_in(1'b0), .vn_in(1'b0),
        .vauxp0(vauxp0), .vauxn0(vauxn0), .vauxp1(vauxp1), .vauxn1(vauxn1)
    );

    always #5 dclk_in = ~dclk_in;

    int nchecks = 0;
    int nerrors = 0;
    int nprint  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
            end
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [15:0] data; } sb_t;
    sb_t         sb[$];
    int          rel = 0;
    int          busy_until = 0;
    logic [15:0] mstat [2];
    logic [15:0] mcfg  [16];
    logic [15:0] mdo = 16'h0000;
    logic [15:0] res = 16'h0000;
    int          acc = 0;
    int          q, m, k, x;

    function automatic logic [15:0] model_read(input logic [6:0] a);
        if (a == 7'h10) return mstat[0];
        if (a == 7'h11) return mstat[1];
        if (a >= 7'h40 && a <= 7'h4F) return mcfg[a[3:0]];
        return 16'h0000;
    endfunction

    // Model: rel counts edges since reset release; conversion k spans PER edges
    always @(posedge dclk_in) begin
        if (reset_in) begin
            rel = 0; busy_until = 0; acc = 0; mdo = 16'h0000; res = 16'h0000;
            sb.delete();
            mstat[0] = 16'h0000; mstat[1] = 16'h0000;
            for (int i = 0; i < 16; i++) mcfg[i] = 16'h0000;
        end else begin
            rel++;
            q = rel - 1; m = q % PER; k = q / PER;
            if (den_w && rel >= busy_until) begin
                busy_until = rel + LAT;
                if (dwe_in) begin
                    if (daddr_w >= 7'h40 && daddr_w <= 7'h4F) mcfg[daddr_w[3:0]] = di_in;
                end else begin
                    mdo = model_read(daddr_w);
                end
                sb.push_back('{due: rel + LAT - 1, data: mdo});
            end
            if (m == 0 && q > 0) mstat[(k - 1) % 2] = res;
            if (m == 0) begin
                acc = 0;
            end else begin
                if (k % 2 == 1) acc += int'(vauxp1 & ~vauxn1);
                else            acc += int'(vauxp0 & ~vauxn0);
                if (m == PER - 1) begin
                    x = acc << (12 - ACQ);
                    if (x > 4095) x = 4095;
                    res = 16'(x << 4);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          mq, mm, mk;
    logic [15:0] exp_hold = 16'h0000;
    sb_t         e;

    always @(negedge dclk_in) begin
        if (reset_in) begin
            chk("rst_busy", busy_out, 1'b0);
            chk("rst_eoc", eoc_out, 1'b0);
            chk("rst_eos", eos_out, 1'b0);
            chk("rst_drdy", drdy_out, 1'b0);
            chk("rst_do", do_out, 16'h0000);
            chk("rst_chan", channel_out, 5'h10);
            exp_hold = 16'h0000;
        end else begin
            if (rel == 0) begin
                chk("idle_busy", busy_out, 1'b0);
                chk("idle_eoc", eoc_out, 1'b0);
                chk("idle_chan", channel_out, 5'h10);
            end else begin
                mq = rel - 1; mm = mq % PER; mk = mq / PER;
                chk("busy", busy_out, (mm != PER - 1));
                chk("eoc", eoc_out, (mm == PER - 1));
                chk("eos", eos_out, (mm == PER - 1) && (mk % 2 == 1));
                chk("chan", channel_out, (mk % 2 == 1) ? 5'h11 : 5'h10);
            end
            chk("alarm", alarm_out, 1'b0);
            while (sb.size() > 0 && sb[0].due < rel) begin
                e = sb.pop_front();
                chk("drdy_missing", rel, e.due);
            end
            if (drdy_out) begin
                if (sb.size() == 0) begin
                    chk("drdy_spurious", drdy_out, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("drdy_time", rel, e.due);
                    chk("drdy_data", do_out, e.data);
                    exp_hold = e.data;
                end
            end else begin
                chk("do_hold", do_out, exp_hold);
            end
        end
    end

    // Analog stimulus: 0 = aux0 full/aux1 zero, 1 = aux1 half duty, else random
    always @(negedge dclk_in) begin
        case (amode)
            0: begin vauxp0 = 1'b1; vauxn0 = 1'b0; vauxp1 = 1'b0; vauxn1 = 1'b0; end
            1: begin vauxp0 = 1'b0; vauxn0 = 1'b0; vauxn1 = 1'b0; vauxp1 = ~vauxp1; end
            default: begin
                vauxp0 = ($urandom_range(0, 3) != 0);
                vauxn0 = ($urandom_range(0, 4) == 0);
                vauxp1 = 1'($urandom_range(0, 1));
                vauxn1 = ($urandom_range(0, 2) == 0);
            end
        endcase
    end

    // ---------------- directed helpers ----------------
    task automatic drp_xfer(input logic [6:0] a, input logic we, input logic [15:0] d,
                            input logic [15:0] exp, input string nm);
        int n;
        @(negedge dclk_in);
        daddr_drv = a; dwe_in = we; di_in = d; den_drv = 1'b1;
        @(negedge dclk_in);
        den_drv = 1'b0; dwe_in = 1'b0;
        n = 1;
        while (!drdy_out && n < 20) begin
            @(negedge dclk_in);
            n++;
        end
        chk({nm, "_lat"}, n, LAT);
        chk(nm, do_out, exp);
    endtask

    task automatic wait_pulse(input bit use_eos, input string nm);
        int n = 0;
        do begin
            @(negedge dclk_in);
            n++;
        end while (!(use_eos ? eos_out : eoc_out) && n < 400);
        chk(nm, (use_eos ? eos_out : eoc_out), 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, r;
        logic [4:0] prev_ch, ch;

        repeat (3) @(negedge dclk_in);
        #2 reset_in = 1'b0;

        // Full-scale aux0, zero aux1
        wait_pulse(1'b1, "first_eos");
        n = 0;
        do begin @(negedge dclk_in); n++; end while (!eos_out && n < 300);
        chk("eos_period", n, 2 * PER);
        drp_xfer(7'h10, 1'b0, 16'h0000, 16'hFFF0, "rd_aux0_full");
        drp_xfer(7'h11, 1'b0, 16'h0000, 16'h0000, "rd_aux1_zero");

        // Config write/readback and ignored status write
        drp_xfer(7'h41, 1'b1, 16'hA5A5, 16'h0000, "wr_cfg41");
        drp_xfer(7'h41, 1'b0, 16'h0000, 16'hA5A5, "rd_cfg41");
        drp_xfer(7'h7F, 1'b0, 16'h0000, 16'h0000, "rd_7f");
        drp_xfer(7'h10, 1'b1, 16'h1234, 16'h0000, "wr_stat_ignored");
        drp_xfer(7'h10, 1'b0, 16'h0000, 16'hFFF0, "rd_aux0_after_wr");

        // Back-to-back enables: one response only
        @(negedge dclk_in);
        daddr_drv = 7'h41; dwe_in = 1'b0; den_drv = 1'b1;
        @(negedge dclk_in);
        @(negedge dclk_in);
        den_drv = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge dclk_in);
            if (drdy_out) cnt++;
        end
        chk("b2b_drdy_cnt", cnt, 1);

        // Half duty on aux1
        amode = 1;
        wait_pulse(1'b1, "half_eos1");
        wait_pulse(1'b1, "half_eos2");
        drp_xfer(7'h11, 1'b0, 16'h0000, 16'h8000, "rd_aux1_half");
        drp_xfer(7'h10, 1'b0, 16'h0000, 16'h0000, "rd_aux0_off");

        // Chained DRP: eoc drives den, address follows channel
        @(negedge dclk_in);
        chain = 1'b1;
        prev_ch = 5'h00;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(1'b0, "chain_eoc");
            ch = channel_out;
            n = 0;
            do begin @(negedge dclk_in); n++; end while (!drdy_out && n < 10);
            chk("chain_lat", n, LAT);
            if (i > 0) chk("chain_alt", ch, prev_ch ^ 5'h01);
            prev_ch = ch;
        end
        @(negedge dclk_in);
        chain = 1'b0;

        // Random analog and DRP traffic against the model
        amode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(negedge dclk_in);
            den_drv = ($urandom_range(0, 5) == 0);
            dwe_in  = ($urandom_range(0, 2) == 0);
            di_in   = 16'($urandom);
            r = $urandom_range(0, 3);
            case (r)
                0: daddr_drv = 7'h10;
                1: daddr_drv = 7'h11;
                2: daddr_drv = 7'h40 | 7'($urandom_range(0, 15));
                default: daddr_drv = 7'($urandom_range(0, 127));
            endcase
        end
        @(negedge dclk_in);
        den_drv = 1'b0; dwe_in = 1'b0;
        repeat (10) @(negedge dclk_in);

        // Mid-conversion asynchronous reset at window cycle 30
        wait_pulse(1'b0, "pre_rst_eoc");
        @(negedge dclk_in);
        repeat (29) @(negedge dclk_in);
        @(posedge dclk_in);
        #3 reset_in = 1'b1;
        #1;
        chk("arst_busy", busy_out, 1'b0);
        chk("arst_chan", channel_out, 5'h10);
        chk("arst_do", do_out, 16'h0000);
        chk("arst_drdy", drdy_out, 1'b0);
        @(negedge dclk_in);
        @(negedge dclk_in);
        #2 reset_in = 1'b0;
        n = 0;
        do begin @(negedge dclk_in); n++; end while (!eoc_out && n < 200);
        chk("rst_first_eoc", n, PER);
        chk("rst_first_chan", channel_out, 5'h10);
        drp_xfer(7'h11, 1'b0, 16'h0000, 16'h0000, "rst_stat1_clr");
        drp_xfer(7'h41, 1'b0, 16'h0000, 16'h0000, "rst_cfg_clr");

        repeat (10) @(negedge dclk_in);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
